// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access controller.
// Converts a pipeline load/store into a single request/ack memory transaction,
// stalls the pipeline while the transaction is outstanding, flags misaligned
// accesses and aborts requests that are never acknowledged.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  MemWrite_MEM,
  input  logic [1:0]  MemRead_MEM,
  input  logic [31:0] Addr_MEM,
  input  logic [31:0] WriteData_MEM,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic [31:0] ReadData_MEM,
  output logic        Stall_MEM,
  output logic        Misaligned,
  output logic        Timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  // Last wait-counter value before the abort fires (counter starts at 0).
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;

  logic [7:0]  r_wait;
  logic [1:0]  r_size;
  logic [1:0]  r_off;

  logic        w_op;
  logic        w_store;
  logic [1:0]  w_size;
  logic        w_misaligned;
  logic        w_issue;
  logic        w_timeout_hit;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  // Decode the incoming operation: store wins over a simultaneous load.
  always_comb begin
    w_store      = (MemWrite_MEM != 2'b00);
    w_op         = w_store || (MemRead_MEM != 2'b00);
    w_size       = w_store ? MemWrite_MEM : MemRead_MEM;
    w_misaligned = ((w_size == SZ_WORD) && (Addr_MEM[1:0] != 2'b00)) ||
                   ((w_size == SZ_HALF) && Addr_MEM[0]);
    w_issue      = w_op && !w_misaligned;
    w_be         = 4'b0000;
    w_wdata      = '0;
    case (w_size)
      SZ_WORD: begin
        w_be    = 4'b1111;
        w_wdata = WriteData_MEM;
      end
      SZ_HALF: begin
        w_be    = 4'b0011 << Addr_MEM[1:0];
        w_wdata = {2{WriteData_MEM[15:0]}};
      end
      SZ_BYTE: begin
        w_be    = 4'b0001 << Addr_MEM[1:0];
        w_wdata = {4{WriteData_MEM[7:0]}};
      end
      default: ;
    endcase
    if (!w_store) begin
      w_wdata = '0;
    end
  end

  // Select and sign-extend the load lane from the returned word.
  always_comb begin
    w_load_data = mem_rdata;
    case (r_size)
      SZ_HALF: begin
        if (r_off[1]) w_load_data = {{16{mem_rdata[31]}}, mem_rdata[31:16]};
        else          w_load_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      end
      SZ_BYTE: begin
        case (r_off)
          2'd0:    w_load_data = {{24{mem_rdata[7]}},  mem_rdata[7:0]};
          2'd1:    w_load_data = {{24{mem_rdata[15]}}, mem_rdata[15:8]};
          2'd2:    w_load_data = {{24{mem_rdata[23]}}, mem_rdata[23:16]};
          default: w_load_data = {{24{mem_rdata[31]}}, mem_rdata[31:24]};
        endcase
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and pipeline stall.
  always_comb begin
    w_next        = r_state;
    Stall_MEM     = 1'b0;
    w_timeout_hit = (r_wait == TO_LAST);
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_next    = S_ACCESS;
          Stall_MEM = 1'b1;
        end
      end
      S_ACCESS: begin
        Stall_MEM = 1'b1;
        if (mem_ack || w_timeout_hit) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields, load result, status flags and wait counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      ReadData_MEM <= '0;
      Misaligned   <= 1'b0;
      Timeout      <= 1'b0;
      r_wait       <= '0;
      r_size       <= '0;
      r_off        <= '0;
    end else begin
      Misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_op && w_misaligned) begin
            Misaligned   <= 1'b1;
            ReadData_MEM <= '0;
          end else if (w_issue) begin
            mem_req   <= 1'b1;
            mem_we    <= w_store;
            mem_addr  <= {Addr_MEM[31:2], 2'b00};
            mem_be    <= w_be;
            mem_wdata <= w_wdata;
            r_size    <= w_size;
            r_off     <= Addr_MEM[1:0];
            r_wait    <= '0;
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_wait  <= '0;
            if (!mem_we) ReadData_MEM <= w_load_data;
          end else if (w_timeout_hit) begin
            mem_req      <= 1'b0;
            Timeout      <= 1'b1;
            ReadData_MEM <= '0;
            r_wait       <= '0;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl.
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  MemWrite_MEM;
  logic [1:0]  MemRead_MEM;
  logic [31:0] Addr_MEM;
  logic [31:0] WriteData_MEM;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] ReadData_MEM;
  logic        Stall_MEM;
  logic        Misaligned;
  logic        Timeout;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(15)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .MemWrite_MEM (MemWrite_MEM),
    .MemRead_MEM  (MemRead_MEM),
    .Addr_MEM     (Addr_MEM),
    .WriteData_MEM(WriteData_MEM),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .ReadData_MEM (ReadData_MEM),
    .Stall_MEM    (Stall_MEM),
    .Misaligned   (Misaligned),
    .Timeout      (Timeout)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_op();
    MemWrite_MEM  = 2'b00;
    MemRead_MEM   = 2'b00;
    Addr_MEM      = '0;
    WriteData_MEM = '0;
  endtask

  initial begin
    Reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    clear_op();
    tick();
    tick();
    Reset = 1'b0;
    #1;
    chk("rst_req",   32'(mem_req),    32'd0);
    chk("rst_rdata", ReadData_MEM,    32'd0);
    chk("rst_to",    32'(Timeout),    32'd0);
    chk("rst_mis",   32'(Misaligned), 32'd0);
    chk("rst_stall", 32'(Stall_MEM),  32'd0);

    // lw 0x104, ack two cycles after the request
    MemRead_MEM = 2'b01;
    Addr_MEM    = 32'h0000_0104;
    #1 chk("lw_stall0", 32'(Stall_MEM), 32'd1);
    tick();
    chk("lw_req",   32'(mem_req),  32'd1);
    chk("lw_we",    32'(mem_we),   32'd0);
    chk("lw_addr",  mem_addr,      32'h0000_0104);
    chk("lw_be",    32'(mem_be),   32'hF);
    chk("lw_wdata", mem_wdata,     32'd0);
    chk("lw_stall1", 32'(Stall_MEM), 32'd1);
    tick();
    chk("lw_hold_req",  32'(mem_req), 32'd1);
    chk("lw_hold_addr", mem_addr,     32'h0000_0104);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1 chk("lw_stall2", 32'(Stall_MEM), 32'd1);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #1;
    chk("lw_done_req",   32'(mem_req),   32'd0);
    chk("lw_rdata",      ReadData_MEM,   32'hDEAD_BEEF);
    chk("lw_done_stall", 32'(Stall_MEM), 32'd0);
    // ack during DONE must be ignored
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0;
    clear_op();
    #1;
    chk("done_ack_rdata", ReadData_MEM, 32'hDEAD_BEEF);
    chk("done_ack_req",   32'(mem_req), 32'd0);

    // lb 0x203 at minimum latency
    MemRead_MEM = 2'b11;
    Addr_MEM    = 32'h0000_0203;
    tick();
    chk("lb_addr", mem_addr,    32'h0000_0200);
    chk("lb_be",   32'(mem_be), 32'h8);
    mem_ack   = 1'b1;
    mem_rdata = 32'h8011_2233;
    tick();
    mem_ack = 1'b0;
    chk("lb_rdata", ReadData_MEM, 32'hFFFF_FF80);
    tick();
    clear_op();

    // sh 0x42 with a simultaneous load request that must be dropped
    MemWrite_MEM  = 2'b10;
    MemRead_MEM   = 2'b10;
    Addr_MEM      = 32'h0000_0042;
    WriteData_MEM = 32'h0000_ABCD;
    tick();
    chk("sh_we",    32'(mem_we),  32'd1);
    chk("sh_addr",  mem_addr,     32'h0000_0040);
    chk("sh_be",    32'(mem_be),  32'hC);
    chk("sh_wdata", mem_wdata,    32'hABCD_ABCD);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    chk("sh_keep_rdata", ReadData_MEM, 32'hFFFF_FF80);
    tick();
    clear_op();

    // misaligned lw 0x102
    MemRead_MEM = 2'b01;
    Addr_MEM    = 32'h0000_0102;
    #1 chk("mis_stall", 32'(Stall_MEM), 32'd0);
    tick();
    clear_op();
    #1;
    chk("mis_pulse", 32'(Misaligned), 32'd1);
    chk("mis_req",   32'(mem_req),    32'd0);
    chk("mis_rdata", ReadData_MEM,    32'd0);
    tick();
    chk("mis_clear",  32'(Misaligned), 32'd0);
    chk("mis_req2",   32'(mem_req),    32'd0);

    // lh 0x2: upper half, positive
    MemRead_MEM = 2'b10;
    Addr_MEM    = 32'h0000_0002;
    tick();
    chk("lh_be", 32'(mem_be), 32'hC);
    mem_ack   = 1'b1;
    mem_rdata = 32'h7FFF_0000;
    tick();
    mem_ack = 1'b0;
    chk("lh_rdata", ReadData_MEM, 32'h0000_7FFF);
    tick();
    clear_op();

    // sw with no ack: abort after 15 ACCESS cycles
    MemWrite_MEM  = 2'b01;
    Addr_MEM      = 32'h0000_0300;
    WriteData_MEM = 32'hCAFE_F00D;
    tick();
    chk("sw_wdata", mem_wdata, 32'hCAFE_F00D);
    for (int i = 0; i < 14; i++) tick();
    chk("to_req_held", 32'(mem_req),   32'd1);
    chk("to_stall",    32'(Stall_MEM), 32'd1);
    chk("to_not_yet",  32'(Timeout),   32'd0);
    tick();
    chk("to_req_drop", 32'(mem_req),   32'd0);
    chk("to_flag",     32'(Timeout),   32'd1);
    chk("to_rdata",    ReadData_MEM,   32'd0);
    tick();
    clear_op();
    tick();
    chk("to_sticky", 32'(Timeout), 32'd1);

    // load a nonzero result so the reset clear below is visible
    MemRead_MEM = 2'b01;
    Addr_MEM    = 32'h0000_0010;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0;
    chk("pre_rst_rdata", ReadData_MEM, 32'h0BAD_F00D);
    tick();
    clear_op();

    // reset during the second ACCESS cycle of an lw
    MemRead_MEM = 2'b01;
    Addr_MEM    = 32'h0000_0108;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    clear_op();
    #1;
    chk("arst_req",   32'(mem_req),   32'd0);
    chk("arst_rdata", ReadData_MEM,   32'd0);
    chk("arst_stall", 32'(Stall_MEM), 32'd0);
    chk("arst_to",    32'(Timeout),   32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_rdata", ReadData_MEM,   32'd0);
    chk("late_ack_req",   32'(mem_req),   32'd0);
    chk("late_ack_stall", 32'(Stall_MEM), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have a parameter TIMEOUT_CYCLES, default 15, giving the maximum number of ACCESS cycles to wait for mem_ack before aborting (legal range 1..255).
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port MemWrite_MEM, input, 2 bits: store size; 00 = none, 01 = word, 10 = half, 11 = byte.
REQ-005 The block SHALL have port MemRead_MEM, input, 2 bits: load size, encoded as for MemWrite_MEM.
REQ-006 The block SHALL have port Addr_MEM, input, 32 bits: byte address of the MEM-stage access.
REQ-007 The block SHALL have port WriteData_MEM, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 The block SHALL have port mem_rdata, input, 32 bits: memory read word, valid in the cycle mem_ack is high.
REQ-009 The block SHALL have port mem_ack, input, 1 bit: single-cycle memory completion.
REQ-010 The block SHALL have port mem_req, output, 1 bit: registered request, held until mem_ack.
REQ-011 The block SHALL have port mem_we, output, 1 bit: registered; 1 = write.
REQ-012 The block SHALL have port mem_addr, output, 32 bits: registered; {Addr_MEM[31:2], 2'b00}.
REQ-013 The block SHALL have port mem_wdata, output, 32 bits: registered; store data replicated into lanes.
REQ-014 The block SHALL have port mem_be, output, 4 bits: registered byte enables; bit i selects byte lane [8i+7:8i].
REQ-015 The block SHALL have port ReadData_MEM, output, 32 bits: registered, sign-extended load result.
REQ-016 The block SHALL have port Stall_MEM, output, 1 bit: combinational; freezes EX8_MEM and all earlier stages.
REQ-017 The block SHALL have port Misaligned, output, 1 bit: registered, one-cycle pulse.
REQ-018 The block SHALL have port Timeout, output, 1 bit: registered, sticky until Reset.

Function
REQ-019 The block SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-020 In IDLE, when an aligned operation is present, the FSM SHALL go to ACCESS and the next edge SHALL register mem_req=1, mem_we, mem_addr, mem_be and mem_wdata.
REQ-021 The operation SHALL be a store when MemWrite_MEM is non-zero; when both MemWrite_MEM and MemRead_MEM are non-zero, the store SHALL win and the read SHALL be dropped.
REQ-022 Byte enables SHALL be: word = 1111; half = 0011 << Addr[1:0]; byte = 0001 << Addr[1:0]; reads SHALL use the same enables with mem_wdata=0.
REQ-023 Store data SHALL be replicated: half = {2{WD[15:0]}}; byte = {4{WD[7:0]}}.
REQ-024 Misalignment SHALL be defined as word with Addr[1:0] != 0, or half with Addr[0] = 1.
REQ-025 On a misaligned operation the block SHALL issue no request, pulse Misaligned for one cycle, set ReadData_MEM to 0, keep Stall_MEM at 0, and stay in IDLE.
REQ-026 In ACCESS, mem_req and all request fields SHALL be held stable until the cycle mem_ack=1.
REQ-027 On mem_ack in ACCESS, the block SHALL capture the load result into ReadData_MEM, drop mem_req at the next edge, and go to DONE.
REQ-028 Load extraction SHALL select the lane by Addr[1:0], little-endian; half and byte SHALL be sign-extended to 32 bits.
REQ-029 Stall_MEM SHALL be 1 in IDLE with an aligned operation present, and 1 in ACCESS.
REQ-030 Stall_MEM SHALL be 0 in DONE and in IDLE with no operation present.
REQ-031 DONE SHALL last exactly one cycle and then return to IDLE, so the held operation is not re-issued.
REQ-032 Minimum latency SHALL be: request at edge 1; ack at earliest in the following cycle; DONE one cycle after ack; 3 cycles total with stall high for 2.
REQ-033 A wait counter SHALL count ACCESS cycles without mem_ack.
REQ-034 When the wait counter reaches TIMEOUT_CYCLES, the block SHALL drop mem_req, set Timeout, set ReadData_MEM to 0, and go to DONE.
REQ-035 mem_ack arriving in IDLE or DONE SHALL be ignored.
REQ-036 ReadData_MEM SHALL hold its value until the next completed load or misaligned event; stores SHALL leave it unchanged.

Reset
REQ-037 While Reset=1 at an edge, the FSM SHALL go to IDLE; mem_req, mem_we, mem_addr, mem_wdata, mem_be, ReadData_MEM, Misaligned, Timeout and the wait counter SHALL be cleared to 0.
REQ-038 A Reset during ACCESS SHALL abort the request with no completion; Stall_MEM SHALL be 0 in the cycle after reset, with no operation present.

Verification
REQ-039 The bench SHALL cover: lw, Addr=0x104, mem_rdata=0xDEADBEEF, ack 2 cycles after req -> mem_addr=0x104, be=1111, ReadData_MEM=0xDEADBEEF, Stall_MEM high for 3 cycles.
REQ-040 The bench SHALL cover: lb, Addr=0x203, mem_rdata=0x80112233 -> be=1000, ReadData_MEM=0xFFFFFF80; lbu is not supported (sign always applied).
REQ-041 The bench SHALL cover: sh, Addr=0x42, WD=0x0000ABCD -> mem_we=1, mem_addr=0x40, be=1100, mem_wdata=0xABCDABCD.
REQ-042 The bench SHALL cover: lw, Addr=0x102 -> Misaligned pulses 1 cycle, no mem_req, Stall_MEM stays 0.
REQ-043 The bench SHALL cover: sw with mem_ack never asserted, TIMEOUT_CYCLES=15 -> mem_req drops after 15 ACCESS cycles, Timeout=1 and stays set.
REQ-044 The bench SHALL cover: Reset asserted in the 2nd ACCESS cycle of an lw -> next cycle mem_req=0, state IDLE, ReadData_MEM=0; a later mem_ack has no effect.
